sram_like_responder: RTL and testbench

- Responder (slave) end of the sram-like instruction/data bus driven by the CPU datapath (req/wr/size/addr/wdata out; addr_ok/data_ok/rdata in).
- Converts each accepted sram-like transaction into one access on a synchronous single-port SRAM with 1-cycle read latency.
- Returns data_ok after a programmable wait.
- One instance serves the inst port and one serves the data port in the SoC-lite top and in unit benches.

---
 rtl/sram_like_responder.sv | 156 +++++++++++++++
 tb/tb_sram_like_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_responder.sv
// sram_like_responder
// Responder end of an sram-like bus. Each accepted request becomes one access
// on a synchronous single-port SRAM with one cycle of read latency. data_ok
// follows after a programmable number of extra wait cycles.
//
// Optional build macro:
//   SRAM_LAT_JITTER_EN - adds a 4-bit LFSR (x^4+x^3+1, seed 4'b1001) whose low
//                        two bits are added to the wait count at each accept.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready, addr_ok=1, request accepted when req=1
// WAIT  | counting down remaining wait cycles before the response
// RESP  | data_ok=1 for exactly one cycle, then back to IDLE

module sram_like_responder #(
    parameter int LATENCY = 1,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [31:0]       rdata,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  wait_cnt;
    logic [4:0]  lat_load;
    logic        accept;
    logic        wr_q;
    logic        first_q;
    logic        bypass_q;
    logic        data_ok_q;
    logic [31:0] rd_buf;
    logic [31:0] rdata_q;

`ifdef SRAM_LAT_JITTER_EN
    logic [3:0] lfsr;

    // Free-running LFSR, restarts from its seed on every reset cycle
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lfsr <= 4'b1001;
        end else begin
            lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
        end
    end

    assign lat_load = 5'(LATENCY) + {3'b000, lfsr[1:0]};
`else
    assign lat_load = 5'(LATENCY);
`endif

    // Handshake: only IDLE accepts, and nothing is accepted while in reset
    assign addr_ok = rstn && (state == IDLE);
    assign accept  = addr_ok && req;
    assign data_ok = rstn && data_ok_q;

    // SRAM side is driven straight from the request in the accept cycle
    assign sram_en    = accept;
    assign sram_addr  = {addr[ADDR_W-1:2], 2'b00};
    assign sram_wdata = wdata;

    // Byte lane enables; misaligned low address bits are simply ignored
    always_comb begin
        sram_wen = 4'b0000;
        if (accept && wr) begin
            case (size)
                2'd0:    sram_wen = 4'b0001 << addr[1:0];
                2'd1:    sram_wen = addr[1] ? 4'b1100 : 4'b0011;
                default: sram_wen = 4'b1111;
            endcase
        end
    end

    // With no wait cycles the SRAM output is forwarded in the response cycle
    assign rdata = (data_ok_q && bypass_q && !wr_q) ? sram_rdata : rdata_q;

    // Transaction FSM: accept, wait count, one-cycle response
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            wait_cnt  <= 5'd0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'd0;
            rd_buf    <= 32'd0;
            wr_q      <= 1'b0;
            first_q   <= 1'b0;
            bypass_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wr_q    <= wr;
                        first_q <= 1'b1;
                        if (lat_load == 5'd0) begin
                            state     <= RESP;
                            data_ok_q <= 1'b1;
                            bypass_q  <= 1'b1;
                            wait_cnt  <= 5'd0;
                        end else begin
                            state    <= WAIT;
                            bypass_q <= 1'b0;
                            wait_cnt <= lat_load;
                        end
                    end
                end
                WAIT: begin
                    // SRAM read data is only valid in the first WAIT cycle
                    first_q <= 1'b0;
                    if (first_q) begin
                        rd_buf <= sram_rdata;
                    end
                    wait_cnt <= wait_cnt - 5'd1;
                    if (wait_cnt == 5'd1) begin
                        state     <= RESP;
                        data_ok_q <= 1'b1;
                        if (!wr_q) begin
                            rdata_q <= first_q ? sram_rdata : rd_buf;
                        end
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    data_ok_q <= 1'b0;
                    first_q   <= 1'b0;
                    if (bypass_q && !wr_q) begin
                        rdata_q <= sram_rdata;
                    end
                end
                default: begin
                    state     <= IDLE;
                    data_ok_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: three instances (LATENCY 1, 0, 3), each with
// its own SRAM, exercised by directed and random transactions and compared
// against a transaction-level reference model.

module tb_sram_like_responder;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn      [N];
    logic        req       [N];
    logic        wr        [N];
    logic [1:0]  size      [N];
    logic [31:0] addr      [N];
    logic [31:0] wdata     [N];
    logic        addr_ok   [N];
    logic        data_ok   [N];
    logic [31:0] rdata     [N];
    logic        sram_en   [N];
    logic [3:0]  sram_wen  [N];
    logic [31:0] sram_addr [N];
    logic [31:0] sram_wdata[N];
    logic [31:0] sram_rdata[N];
`ifdef SRAM_LAT_JITTER_EN
    logic [3:0]  lfsr_w    [N];
`endif

    logic [31:0] ref_mem [N][64];
    logic [31:0] last_rd [N];

    int total = 0;
    int bad   = 0;

    function automatic int lat_of(input int k);
        if (k == 0) return 1;
        if (k == 1) return 0;
        return 3;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        logic [31:0] mem [64];
        logic [31:0] rd_r;

        sram_like_responder #(.LATENCY(L), .ADDR_W(32)) u_dut (
            .clk        (clk),
            .rstn       (rstn[g]),
            .req        (req[g]),
            .wr         (wr[g]),
            .size       (size[g]),
            .addr       (addr[g]),
            .wdata      (wdata[g]),
            .addr_ok    (addr_ok[g]),
            .data_ok    (data_ok[g]),
            .rdata      (rdata[g]),
            .sram_en    (sram_en[g]),
            .sram_wen   (sram_wen[g]),
            .sram_addr  (sram_addr[g]),
            .sram_wdata (sram_wdata[g]),
            .sram_rdata (sram_rdata[g])
        );

        initial begin
            for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        end

        // Behavioural SRAM: garbage on the read port unless read last cycle
        always @(posedge clk) begin
            if (sram_en[g]) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_wen[g][b]) mem[sram_addr[g][7:2]][8*b +: 8] <= sram_wdata[g][8*b +: 8];
                end
                rd_r <= mem[sram_addr[g][7:2]];
            end else begin
                rd_r <= $urandom;
            end
        end
        assign sram_rdata[g] = rd_r;

`ifdef SRAM_LAT_JITTER_EN
        logic [3:0] lf;
        always @(posedge clk) begin
            if (!rstn[g]) lf <= 4'b1001;
            else          lf <= {lf[2:0], lf[3] ^ lf[2]};
        end
        assign lfsr_w[g] = lf;
`endif
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int jitter(input int k);
`ifdef SRAM_LAT_JITTER_EN
        return int'(lfsr_w[k][1:0]);
`else
        return 0 * k;
`endif
    endfunction

    // Expected byte lanes from the request's size and low address bits
    function automatic logic [3:0] model_mask(input logic w, input logic [1:0] sz, input logic [31:0] a);
        int lane;
        if (!w) return 4'b0000;
        lane = int'(a % 4);
        case (sz)
            2'd0:    return 4'(1 << lane);
            2'd1:    return 4'(3 << (2 * (lane / 2)));
            default: return 4'b1111;
        endcase
    endfunction

    // One full transaction: accept cycle, wait cycles, response cycle
    task automatic txn(input int k, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input logic keep);
        int          lat;
        int          widx;
        logic [3:0]  mask;
        logic [31:0] exp_rd;
        @(negedge clk);
        req[k] = 1'b1; wr[k] = w; size[k] = sz; addr[k] = a; wdata[k] = wd;
        #1;
        lat  = lat_of(k) + jitter(k);
        mask = model_mask(w, sz, a);
        widx = int'(a[7:2]);
        check_eq("acc_addr_ok",  32'(addr_ok[k]), 32'd1);
        check_eq("acc_sram_en",  32'(sram_en[k]), 32'd1);
        check_eq("acc_sram_wen", 32'(sram_wen[k]), 32'(mask));
        check_eq("acc_sram_addr", sram_addr[k], {a[31:2], 2'b00});
        check_eq("acc_sram_wdata", sram_wdata[k], wd);
        exp_rd = ref_mem[k][widx];
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) ref_mem[k][widx][8*b +: 8] = wd[8*b +: 8];
        end
        for (int n = 1; n <= lat + 1; n++) begin
            @(negedge clk);
            if (n == 1 && !keep) req[k] = 1'b0;
            #1;
            check_eq("data_ok_timing", 32'(data_ok[k]), 32'(n == lat + 1));
            check_eq("busy_addr_ok",   32'(addr_ok[k]), 32'd0);
            check_eq("busy_sram_en",   32'(sram_en[k]), 32'd0);
        end
        if (!w) last_rd[k] = exp_rd;
        check_eq(w ? "wr_rdata_hold" : "rd_rdata", rdata[k], last_rd[k]);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            rstn[k] = 1'b0; req[k] = 1'b1; wr[k] = 1'b0; size[k] = 2'd2;
            addr[k] = 32'h10; wdata[k] = 32'd0; last_rd[k] = 32'd0;
            for (int i = 0; i < 64; i++) ref_mem[k][i] = 32'd0;
        end

        // Two reset cycles with a pending request on the bus
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                check_eq("rst_addr_ok", 32'(addr_ok[k]), 32'd0);
                check_eq("rst_sram_en", 32'(sram_en[k]), 32'd0);
                check_eq("rst_data_ok", 32'(data_ok[k]), 32'd0);
                check_eq("rst_rdata",   rdata[k], 32'd0);
            end
        end
        for (int k = 0; k < N; k++) begin
            rstn[k] = 1'b1; req[k] = 1'b0;
        end
        #1;
        for (int k = 0; k < N; k++) check_eq("rel_addr_ok", 32'(addr_ok[k]), 32'd1);

        // Word write, read-back, then sub-word writes on the LATENCY=1 instance
        txn(0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0);
        txn(0, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0);
        check_eq("readback_value", rdata[0], 32'hDEADBEEF);
        txn(0, 1'b1, 2'd0, 32'h13, 32'h11223344, 1'b0);
        check_eq("rdata_after_wr", rdata[0], 32'hDEADBEEF);
        txn(0, 1'b1, 2'd1, 32'h12, 32'h55667788, 1'b0);
        txn(0, 1'b1, 2'd3, 32'h11, 32'hCAFEF00D, 1'b0);
        txn(0, 1'b1, 2'd0, 32'h21, 32'hA5A5A5A5, 1'b0);
        txn(0, 1'b1, 2'd1, 32'h20, 32'h3C3C3C3C, 1'b0);
        txn(0, 1'b0, 2'd2, 32'h20, 32'h0, 1'b0);

        // Streaming reads with req held high on the LATENCY=0 instance
        txn(1, 1'b1, 2'd2, 32'h40, 32'h01020304, 1'b0);
        txn(1, 1'b0, 2'd2, 32'h40, 32'h0, 1'b1);
        txn(1, 1'b0, 2'd2, 32'h44, 32'h0, 1'b1);
        txn(1, 1'b0, 2'd2, 32'h40, 32'h0, 1'b0);

        // Reset while in WAIT on the LATENCY=3 instance
        txn(2, 1'b1, 2'd2, 32'h30, 32'h87654321, 1'b0);
        txn(2, 1'b0, 2'd2, 32'h30, 32'h0, 1'b0);
        @(negedge clk);
        req[2] = 1'b1; wr[2] = 1'b0; size[2] = 2'd2; addr[2] = 32'h30;
        #1;
        check_eq("rw_accept", 32'(addr_ok[2]), 32'd1);
        @(negedge clk);
        req[2] = 1'b0;
        #1;
        check_eq("rw_t1_data_ok", 32'(data_ok[2]), 32'd0);
        @(negedge clk);
        rstn[2] = 1'b0; req[2] = 1'b1;
        #1;
        check_eq("rw_t2_data_ok", 32'(data_ok[2]), 32'd0);
        check_eq("rw_t2_addr_ok", 32'(addr_ok[2]), 32'd0);
        check_eq("rw_t2_sram_en", 32'(sram_en[2]), 32'd0);
        @(negedge clk);
        rstn[2] = 1'b1; req[2] = 1'b0;
        #1;
        last_rd[2] = 32'd0;
        check_eq("rw_t3_addr_ok", 32'(addr_ok[2]), 32'd1);
        check_eq("rw_t3_data_ok", 32'(data_ok[2]), 32'd0);
        check_eq("rw_t3_rdata",   rdata[2], 32'd0);
        for (int c = 4; c <= 8; c++) begin
            @(negedge clk);
            #1;
            check_eq("rw_no_data_ok", 32'(data_ok[2]), 32'd0);
            check_eq("rw_idle_addr_ok", 32'(addr_ok[2]), 32'd1);
        end
        txn(2, 1'b0, 2'd2, 32'h30, 32'h0, 1'b0);

        // Random traffic, one instance at a time
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 20; i++) begin
                txn(k, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    32'($urandom_range(0, 255)), $urandom,
                    (i < 19) ? 1'($urandom_range(0, 1)) : 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
